// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and load-type codes for the MIPS datapath.
//   DATA_W  - datapath width
//   REG_AW  - register-number width
//   load_type_e - encoding of the load width/extension carried down the pipe
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational byte/halfword lane select and extension for
// loads, plus alignment check.
//   load_type_i - load type code (unknown codes behave as LW)
//   byte_off_i  - address[1:0] of the load
//   rdata_i     - raw aligned memory word
//   data_o      - extracted, extended load value
//   misalign_o  - access is not naturally aligned for its width
module load_extract
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic [2:0]        load_type_i,
    input  logic [1:0]        byte_off_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lanes: byte lane = offset, halfword lane = offset[1].
    assign byte_sel = rdata_i[{byte_off_i, 3'b000} +: 8];
    assign half_sel = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o     = rdata_i;
        misalign_o = 1'b0;
        case (load_type_i)
            LT_LB: begin
                data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            end
            LT_LBU: begin
                data_o = {{(DATA_W-8){1'b0}}, byte_sel};
            end
            LT_LH: begin
                data_o     = {{(DATA_W-16){half_sel[15]}}, half_sel};
                misalign_o = byte_off_i[0];
            end
            LT_LHU: begin
                data_o     = {{(DATA_W-16){1'b0}}, half_sel};
                misalign_o = byte_off_i[0];
            end
            default: begin
                data_o     = rdata_i;
                misalign_o = (byte_off_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register. Captures memory-stage results,
// selects the writeback value, and drives the register-file write port.
//   clock, reset_n        - clock, async active-low reset
//   in_valid/stall/flush  - pipeline control
//   in_regwrite, in_memtoreg, in_load_type, in_byte_off,
//   in_alu_result, in_mem_rdata, in_rd - MEM-stage instruction fields
//   RegWrite/WriteReg/WriteData - register-file write port
//   fwd_valid/fwd_reg/fwd_data  - bypass bus for same-cycle readers
//   misalign      - one-cycle pulse when a misaligned load is dropped
//   retire_count  - number of committed register writes (wrapping)
module mem_wb_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_byte_off,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    input  logic [REG_AW-1:0] in_rd,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              misalign,
    output logic [CNT_W-1:0]  retire_count
);

    logic              valid_q;
    logic              regwrite_q;
    logic              done_q;
    logic              misalign_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] result_q;
    logic [CNT_W-1:0]  retire_q;

    logic [DATA_W-1:0] load_data;
    logic              load_misalign;
    logic              bad_load;
    logic              valid_d;
    logic              regwrite_d;
    logic [DATA_W-1:0] result_d;
    logic              commit;

    load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .load_type_i (in_load_type),
        .byte_off_i  (in_byte_off),
        .rdata_i     (in_mem_rdata),
        .data_o      (load_data),
        .misalign_o  (load_misalign)
    );

    // Alignment only matters when the load data is actually the result.
    assign bad_load   = in_memtoreg & load_misalign;
    assign valid_d    = in_valid & ~flush;
    assign result_d   = in_memtoreg ? load_data : in_alu_result;
    // r0 is hardwired zero: never written and never counted as a retire.
    assign regwrite_d = in_regwrite & ~bad_load & (in_rd != '0);

    // done_q marks that the held instruction already had its write cycle,
    // so a long stall still produces exactly one write pulse.
    assign commit = valid_q & regwrite_q & ~done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            retire_q   <= '0;
        end else begin
            misalign_q <= 1'b0;
            if (!stall) begin
                valid_q    <= valid_d;
                regwrite_q <= regwrite_d;
                rd_q       <= in_rd;
                result_q   <= result_d;
                done_q     <= 1'b0;
                misalign_q <= valid_d & bad_load;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else begin
                done_q <= valid_q;
            end
            if (commit) begin
                retire_q <= retire_q + CNT_W'(1);
            end
        end
    end

    assign RegWrite     = commit;
    assign WriteReg     = rd_q;
    assign WriteData    = result_q;
    assign fwd_valid    = valid_q & regwrite_q;
    assign fwd_reg      = rd_q;
    assign fwd_data     = result_q;
    assign misalign     = misalign_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, stall, flush, in_regwrite, in_memtoreg;
    logic [2:0]  in_load_type;
    logic [1:0]  in_byte_off;
    logic [31:0] in_alu_result, in_mem_rdata;
    logic [4:0]  in_rd;
    logic        RegWrite, fwd_valid, misalign;
    logic [4:0]  WriteReg, fwd_reg;
    logic [31:0] WriteData, fwd_data, retire_count;

    int vectors = 0;
    int errors  = 0;
    int rw_cnt, fv_cnt;

    always #5 clock = ~clock;

    mem_wb_stage dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .in_regwrite   (in_regwrite),
        .in_memtoreg   (in_memtoreg),
        .in_load_type  (in_load_type),
        .in_byte_off   (in_byte_off),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_rd         (in_rd),
        .RegWrite      (RegWrite),
        .WriteReg      (WriteReg),
        .WriteData     (WriteData),
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
        .misalign      (misalign),
        .retire_count  (retire_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [1:0] off, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [4:0] rd);
        in_valid      = v;
        in_regwrite   = rw;
        in_memtoreg   = m2r;
        in_load_type  = lt;
        in_byte_off   = off;
        in_alu_result = alu;
        in_mem_rdata  = rdat;
        in_rd         = rd;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        idle();
        #2;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_writereg", WriteReg, 0);
        chk("rst_writedata", WriteData, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_retire", retire_count, 0);
        step();
        step();
        @(negedge clock);
        reset_n = 1'b1;

        // ALU writeback, then back-to-back loads on 0x80FF_7F01
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 5'd8);
        step();
        chk("alu_regwrite", RegWrite, 1);
        chk("alu_writereg", WriteReg, 8);
        chk("alu_writedata", WriteData, 32'h1234_5678);
        chk("alu_fwd_valid", fwd_valid, 1);
        chk("alu_fwd_data", fwd_data, 32'h1234_5678);
        chk("alu_retire", retire_count, 0);

        drive(1'b1, 1'b1, 1'b1, 3'b001, 2'd3, 32'h0, 32'h80FF_7F01, 5'd9);
        step();
        chk("lb_regwrite", RegWrite, 1);
        chk("lb_writereg", WriteReg, 9);
        chk("lb_data", WriteData, 32'hFFFF_FF80);
        chk("lb_retire", retire_count, 1);

        drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd2, 32'h0, 32'h80FF_7F01, 5'd10);
        step();
        chk("lbu_data", WriteData, 32'h0000_00FF);
        chk("lbu_fwd_reg", fwd_reg, 10);
        chk("lbu_retire", retire_count, 2);

        drive(1'b1, 1'b1, 1'b1, 3'b011, 2'd2, 32'h0, 32'h80FF_7F01, 5'd11);
        step();
        chk("lh_data", WriteData, 32'hFFFF_80FF);
        chk("lh_regwrite", RegWrite, 1);

        drive(1'b1, 1'b1, 1'b1, 3'b100, 2'd0, 32'h0, 32'h80FF_7F01, 5'd12);
        step();
        chk("lhu_data", WriteData, 32'h0000_7F01);
        chk("lhu_retire", retire_count, 4);

        idle();
        step();
        chk("idle_regwrite", RegWrite, 0);
        chk("idle_fwd_valid", fwd_valid, 0);
        chk("idle_retire", retire_count, 5);

        // Stall 4 cycles after capturing rd=5
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_CAFE, 32'h0, 5'd5);
        step();
        rw_cnt = int'(RegWrite);
        fv_cnt = int'(fwd_valid);
        idle();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            rw_cnt += int'(RegWrite);
            fv_cnt += int'(fwd_valid);
        end
        chk("stall_hold_data", WriteData, 32'h0000_CAFE);
        chk("stall_hold_reg", WriteReg, 5);
        stall = 1'b0;
        step();
        rw_cnt += int'(RegWrite);
        fv_cnt += int'(fwd_valid);
        chk("stall_rw_pulses", rw_cnt, 1);
        chk("stall_fwd_cycles", fv_cnt, 5);
        chk("stall_retire", retire_count, 6);

        // rd=0 write, then misaligned LW
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 5'd0);
        step();
        chk("r0_regwrite", RegWrite, 0);
        chk("r0_misalign", misalign, 0);
        drive(1'b1, 1'b1, 1'b1, 3'b000, 2'd1, 32'h0, 32'h1111_2222, 5'd7);
        step();
        chk("lw_mis_regwrite", RegWrite, 0);
        chk("lw_mis_pulse", misalign, 1);
        idle();
        step();
        chk("lw_mis_pulse_end", misalign, 0);
        chk("mis_retire", retire_count, 6);

        // Flush while stalled
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0033, 32'h0, 5'd3);
        step();
        chk("fl_regwrite", RegWrite, 1);
        idle();
        stall = 1'b1;
        flush = 1'b1;
        step();
        chk("fl_fwd_valid", fwd_valid, 0);
        chk("fl_regwrite_after", RegWrite, 0);
        stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0044, 32'h0, 5'd4);
        step();
        chk("fl_nostall_fwd", fwd_valid, 0);
        chk("fl_retire", retire_count, 7);
        flush = 1'b0;
        idle();

        // Counter wrap
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        chk("wrap_preset", retire_count, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0055, 32'h0, 5'd4);
        step();
        chk("wrap_regwrite", RegWrite, 1);
        idle();
        step();
        chk("wrap_zero", retire_count, 0);

        // Async reset mid-stall
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0066, 32'h0, 5'd6);
        step();
        idle();
        stall = 1'b1;
        step();
        chk("rs_pre_fwd", fwd_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_regwrite", RegWrite, 0);
        chk("rs_fwd_valid", fwd_valid, 0);
        chk("rs_writereg", WriteReg, 0);
        chk("rs_writedata", WriteData, 0);
        chk("rs_retire", retire_count, 0);
        step();
        @(negedge clock);
        reset_n = 1'b1;
        stall   = 1'b0;
        rw_cnt  = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            rw_cnt += int'(RegWrite);
        end
        chk("rs_no_write", rw_cnt, 0);
        chk("rs_retire_after", retire_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
